// File: rtl/argmax_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : argmax_stream_ctrl
// Desc     : Collects 2**SIZE unsigned samples per frame over valid/ready and
//            returns the frame maximum and its index over a second handshake.
// Revision : 1.0 - initial release
// ============================================================================
module argmax_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [SIZE-1:0]  out_argmax,
    output logic [7:0]       frame_cnt
);

    localparam int              c_DEPTH = 1 << SIZE;
    localparam logic [SIZE-1:0] c_LAST  = '1;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_accept;

    logic [WIDTH-1:0] r_buf [c_DEPTH];
    logic [SIZE-1:0]  r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_max;
    logic [SIZE-1:0]  r_out_argmax;
    logic [7:0]       r_frame_cnt;

    logic [WIDTH-1:0] w_tree_max;
    logic [SIZE-1:0]  w_tree_idx;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        unique case (r_state)
            S_FILL: begin
                w_in_ready = rst_n && !flush;
                if (w_in_ready && in_valid && (r_cnt == c_LAST)) begin
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign w_accept = w_in_ready && in_valid;

    // ------------------------------------------------------------------
    // Frame buffer (contents are don't-care until written, so no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_cnt] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Comparator tree: level l holds c_DEPTH >> l nodes. The value path
    // uses >= and the index path a strict left > right, so on a tie the
    // right (higher-index) subtree supplies the index.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= SIZE; l++) begin : g_lvl
        localparam int c_NODES = c_DEPTH >> l;

        logic [WIDTH-1:0] w_val [c_NODES];
        logic [SIZE-1:0]  w_idx [c_NODES];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < c_NODES; i++) begin : g_slot
                assign w_val[i] = r_buf[i];
                assign w_idx[i] = SIZE'(i);
            end
        end else begin : g_cmp
            for (genvar i = 0; i < c_NODES; i++) begin : g_node
                logic [WIDTH-1:0] w_lval;
                logic [WIDTH-1:0] w_rval;
                logic [SIZE-1:0]  w_lidx;
                logic [SIZE-1:0]  w_ridx;

                assign w_lval   = g_lvl[l-1].w_val[2*i];
                assign w_rval   = g_lvl[l-1].w_val[2*i+1];
                assign w_lidx   = g_lvl[l-1].w_idx[2*i];
                assign w_ridx   = g_lvl[l-1].w_idx[2*i+1];
                assign w_val[i] = (w_lval >= w_rval) ? w_lval : w_rval;
                assign w_idx[i] = (w_lval >  w_rval) ? w_lidx : w_ridx;
            end
        end
    end

    assign w_tree_max = g_lvl[SIZE].w_val[0];
    assign w_tree_idx = g_lvl[SIZE].w_idx[0];

    // ------------------------------------------------------------------
    // Slot counter, result registers and handshake counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_max    <= '0;
            r_out_argmax <= '0;
            r_frame_cnt  <= '0;
        end else begin
            if ((r_state == S_FILL) && flush) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                // Wraps to 0 naturally on the last slot of the frame.
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_EVAL) begin
                r_out_valid  <= 1'b1;
                r_out_max    <= w_tree_max;
                r_out_argmax <= w_tree_idx;
            end else if ((r_state == S_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_max    = r_out_max;
    assign out_argmax = r_out_argmax;
    assign frame_cnt  = r_frame_cnt;

    // The two handshakes are mutually exclusive by construction.
    a_excl_hs : assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_valid_in_done : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid == (r_state == S_DONE));

endmodule

`default_nettype wire

// File: tb/tb_argmax_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_stream_ctrl
// Desc     : Scoreboard bench for argmax_stream_ctrl in two configurations
//            (WIDTH=8/SIZE=2 with directed + random, WIDTH=16/SIZE=3 random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit done_flag [2];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    for (genvar c = 0; c < 2; c++) begin : g_cfg
        localparam int W  = (c == 0) ? 8 : 16;
        localparam int S  = (c == 0) ? 2 : 3;
        localparam int N  = 1 << S;
        localparam int NF = (c == 0) ? 256 : 60;

        logic         rst_n;
        logic         flush;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] in_data;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] out_max;
        logic [S-1:0] out_argmax;
        logic [7:0]   frame_cnt;

        argmax_stream_ctrl #(
            .WIDTH (W),
            .SIZE  (S)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_data    (in_data),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_max    (out_max),
            .out_argmax (out_argmax),
            .frame_cnt  (frame_cnt)
        );

        // Reference model state: accepted samples of the open frame, queued
        // expected results, and whether a frame is awaiting its handshake.
        int frame_q[$];
        int exp_max[$];
        int exp_idx[$];
        bit busy     = 1'b0;
        int age      = 0;
        int hs       = 0;
        bit shown    = 1'b0;
        bit rst_seen = 1'b0;
        int cur_max  = 0;
        int cur_idx  = 0;
        bit rnd_or   = 1'b0;

        function automatic void ck(input string n, input logic [31:0] a,
                                   input logic [31:0] e);
            chk($sformatf("cfg%0d_%s", c, n), a, e);
        endfunction

        // Monitor / scoreboard: inputs change just after posedge, so at the
        // negedge everything for the coming edge is settled.
        always @(negedge clk) begin : mon
            if (rst_n !== 1'b1) begin
                ck("in_ready_in_reset", in_ready, 0);
                busy     = 1'b0;
                age      = 0;
                hs       = 0;
                shown    = 1'b0;
                rst_seen = 1'b1;
                frame_q.delete();
                exp_max.delete();
                exp_idx.delete();
            end else begin
                if (rst_seen) begin
                    ck("rst_out_valid", out_valid, 0);
                    ck("rst_out_max", out_max, 0);
                    ck("rst_out_argmax", out_argmax, 0);
                    ck("rst_frame_cnt", frame_cnt, 0);
                    rst_seen = 1'b0;
                end
                ck("in_ready", in_ready, (!busy && !flush));
                ck("out_valid", out_valid, (busy && age >= 1));
                if (busy && age >= 1) begin
                    if (!shown) begin
                        cur_max = exp_max.pop_front();
                        cur_idx = exp_idx.pop_front();
                        shown   = 1'b1;
                    end
                    ck("out_max", out_max, cur_max);
                    ck("out_argmax", out_argmax, cur_idx);
                    ck("frame_cnt", frame_cnt, hs % 256);
                end

                if (busy) begin
                    if (age >= 1 && out_ready) begin
                        busy  = 1'b0;
                        shown = 1'b0;
                        hs++;
                    end
                    age++;
                end else if (flush) begin
                    frame_q.delete();
                end else if (in_valid) begin
                    frame_q.push_back(int'(in_data));
                    if (frame_q.size() == N) begin
                        int best;
                        int bidx;
                        best = 0;
                        bidx = 0;
                        for (int i = 0; i < N; i++) begin
                            if (frame_q[i] >= best) begin
                                best = frame_q[i];
                                bidx = i;
                            end
                        end
                        exp_max.push_back(best);
                        exp_idx.push_back(bidx);
                        frame_q.delete();
                        busy = 1'b1;
                        age  = 0;
                    end
                end
            end
        end

        always @(posedge clk) begin
            if (rnd_or) begin
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic send(input int d);
            int t;
            t        = 0;
            in_valid = 1'b1;
            in_data  = W'(d);
            @(negedge clk);
            while (in_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) ck("send_timeout", in_ready, 1);
            tick();
            in_valid = 1'b0;
        endtask

        task automatic send4(input int a, input int b, input int d, input int e);
            send(a);
            send(b);
            send(d);
            send(e);
        endtask

        task automatic wait_valid();
            int t;
            t = 0;
            @(negedge clk);
            while (out_valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) ck("wait_valid_timeout", out_valid, 1);
            tick();
        endtask

        initial begin : drv
            int t;
            rst_n     = 1'b0;
            flush     = 1'b0;
            in_valid  = 1'b0;
            in_data   = '0;
            out_ready = 1'b1;
            repeat (3) tick();
            rst_n = 1'b1;
            tick();

            if (c == 0) begin
                // basic frame and tie cases
                send4(3, 9, 1, 7);
                send4(5, 5, 2, 5);
                send4(200, 200, 200, 200);
                send4(255, 0, 0, 0);
                repeat (3) tick();

                // backpressure
                out_ready = 1'b0;
                send4(10, 40, 30, 20);
                wait_valid();
                repeat (5) tick();
                out_ready = 1'b1;
                repeat (3) tick();

                // flush: 99 offered with flush must not be accepted
                send(8);
                send(9);
                flush    = 1'b1;
                in_valid = 1'b1;
                in_data  = W'(99);
                tick();
                flush    = 1'b0;
                in_valid = 1'b0;
                send4(0, 0, 0, 0);
                repeat (3) tick();

                // reset mid-frame
                send(1);
                send(2);
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                send4(1, 2, 3, 4);
                repeat (3) tick();

                // reset while a result is waiting in DONE
                out_ready = 1'b0;
                send4(6, 7, 8, 9);
                wait_valid();
                tick();
                rst_n     = 1'b0;
                out_ready = 1'b1;
                tick();
                rst_n = 1'b1;
                send4(1, 2, 3, 4);
                repeat (3) tick();
            end

            // randomized frames with throttled producer and consumer
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
            rnd_or = 1'b1;
            for (int f = 0; f < NF; f++) begin
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    if (c == 1 && $urandom_range(0, 23) == 0) begin
                        flush    = 1'b1;
                        in_valid = 1'b1;
                        in_data  = W'($urandom_range(0, (1 << W) - 1));
                        tick();
                        flush    = 1'b0;
                        in_valid = 1'b0;
                    end
                    if ($urandom_range(0, 3) == 0)
                        send(((1 << W) - 1) - $urandom_range(0, 1));
                    else
                        send($urandom_range(0, (1 << W) - 1));
                end
            end
            t = 0;
            while (busy && t < 2000) begin
                tick();
                t++;
            end
            rnd_or = 1'b0;
            tick();
            tick();
            ck("drain_pending", exp_max.size(), 0);
            ck("final_frame_cnt", frame_cnt, hs % 256);
            done_flag[c] = 1'b1;
        end
    end

    initial begin : fin
        int t;
        t = 0;
        while (!(done_flag[0] && done_flag[1]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60000) chk("global_timeout", done_flag[0] & done_flag[1], 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
